// File: rtl/gon_pkg.sv
// rtl/gon_pkg.sv - shared types and defaults for the tagged multicast bus transmitter
package gon_pkg;

    localparam int GON_TAG_WIDTH  = 4;
    localparam int GON_DATA_WIDTH = 64;

    typedef struct packed {
        logic [GON_TAG_WIDTH-1:0]  tag;
        logic [GON_DATA_WIDTH-1:0] data;
    } gon_pkt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } gon_tx_state_e;

endpackage

// File: rtl/gon_pkt_fifo.sv
// rtl/gon_pkt_fifo.sv - synchronous packet FIFO with wrap-bit full/empty detection
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_pkt  : write strobe and packet (ignored when full)
//   pop             : advance read pointer (ignored when empty)
//   head            : oldest stored packet
//   full, empty     : occupancy flags
module gon_pkt_fifo
    import gon_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter type pkt_t      = gon_pkt_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  pkt_t push_pkt,
    input  logic pop,
    output pkt_t head,
    output logic full,
    output logic empty
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    pkt_t              mem [FIFO_DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // addresses with differing wrap bits mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign head  = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[ADDR_W-1:0]] <= push_pkt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/gon_tag_tx.sv
// rtl/gon_tag_tx.sv - bus-side transmitter: buffers (tag, data) packets and drives them onto the multicast bus
//   link_clk, reset         : bus clock, asynchronous active-low reset
//   in_data/in_tag/in_valid : upstream packet, accepted when in_ready is high
//   in_ready                : buffer has room
//   data_out/tag_out        : registered bus payload, zero when idle
//   enable_out              : bus packet valid
//   ready_in                : combined ready of all multicast controllers
//   busy                    : packet buffered or on the bus
//   stall_timeout           : sticky flag, bus held without ready for STALL_LIMIT cycles
//   sent_count              : completed bus transfers, wrapping at 2^16
module gon_tag_tx
    import gon_pkg::*;
#(
    parameter int DATA_WIDTH  = GON_DATA_WIDTH,
    parameter int TAG_WIDTH   = GON_TAG_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int STALL_LIMIT = 255
) (
    input  logic                  link_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [TAG_WIDTH-1:0]  tag_out,
    output logic                  enable_out,
    input  logic                  ready_in,
    output logic                  busy,
    output logic                  stall_timeout,
    output logic [15:0]           sent_count
);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } pkt_t;

    localparam logic [15:0] STALL_MAX = 16'(STALL_LIMIT);

    gon_tx_state_e state_q;
    gon_tx_state_e state_d;

    pkt_t        in_pkt;
    pkt_t        head_pkt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        load;
    logic        clear;
    logic        xfer;
    logic [15:0] stall_cnt_q;

    assign in_pkt     = '{tag: in_tag, data: in_data};
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign enable_out = (state_q == SEND);
    assign xfer       = enable_out && ready_in;
    assign busy       = enable_out || !fifo_empty;

    gon_pkt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .pkt_t      (pkt_t)
    ) u_fifo (
        .clk      (link_clk),
        .rst_n    (reset),
        .push     (push),
        .push_pkt (in_pkt),
        .pop      (pop),
        .head     (head_pkt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ready_in) begin
                    // Chain straight into the next buffered packet so a
                    // continuously ready bus carries one packet per cycle.
                    if (!fifo_empty) begin
                        load = 1'b1;
                        pop  = 1'b1;
                    end else begin
                        clear   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                clear   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            data_out <= '0;
            tag_out  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_out <= head_pkt.data;
                tag_out  <= head_pkt.tag;
            end else if (clear) begin
                data_out <= '0;
                tag_out  <= '0;
            end
        end
    end

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            sent_count <= '0;
        end else if (xfer) begin
            sent_count <= sent_count + 16'd1;
        end
    end

    // The flag sets on the edge that brings the count to STALL_MAX; the
    // counter then saturates so it never wraps back under the limit.
    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q   <= '0;
            stall_timeout <= 1'b0;
        end else if (enable_out && !ready_in) begin
            if (stall_cnt_q != STALL_MAX) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (stall_cnt_q >= STALL_MAX - 16'd1) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            stall_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_gon_tag_tx.sv
// tb/tb_gon_tag_tx.sv - self-checking bench for gon_tag_tx against a packet-queue reference model
module tb_gon_tag_tx;

    localparam int DW    = 64;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } pkt_s;

    logic          link_clk = 1'b0;
    logic          reset    = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic [TW-1:0] in_tag   = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic [TW-1:0] tag_out;
    logic          enable_out;
    logic          ready_in = 1'b0;
    logic          busy;
    logic          stall_timeout;
    logic [15:0]   sent_count;

    always #5 link_clk = ~link_clk;

    gon_tag_tx #(
        .DATA_WIDTH  (DW),
        .TAG_WIDTH   (TW),
        .FIFO_DEPTH  (DEPTH),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .link_clk      (link_clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_tag        (in_tag),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_out      (data_out),
        .tag_out       (tag_out),
        .enable_out    (enable_out),
        .ready_in      (ready_in),
        .busy          (busy),
        .stall_timeout (stall_timeout),
        .sent_count    (sent_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: every accepted-but-untransferred packet in order,
    // plus whether the oldest one is currently presented on the bus.
    pkt_s        q[$];
    bit          on_bus     = 1'b0;
    int          stall_run  = 0;
    bit          stall_flag = 1'b0;
    logic [15:0] sent_exp   = '0;

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        on_bus     = 1'b0;
        stall_run  = 0;
        stall_flag = 1'b0;
        sent_exp   = '0;
    endtask

    task automatic check_all();
        int buffered;
        buffered = q.size() - int'(on_bus);
        chk("enable_out", enable_out, on_bus);
        chk("tag_out", tag_out, on_bus ? q[0].tag : '0);
        chk("data_out", data_out, on_bus ? q[0].data : '0);
        chk("in_ready", in_ready, buffered < DEPTH);
        chk("busy", busy, q.size() > 0);
        chk("sent_count", sent_count, sent_exp);
        chk("stall_timeout", stall_timeout, stall_flag);
    endtask

    task automatic step(input bit do_check);
        int   buffered;
        bit   push;
        bit   xfer;
        pkt_s p;
        buffered = q.size() - int'(on_bus);
        push     = in_valid && (buffered < DEPTH);
        xfer     = on_bus && ready_in;
        p        = '{tag: in_tag, data: in_data};
        @(posedge link_clk);
        if (on_bus && !ready_in) begin
            if (stall_run < LIMIT) stall_run++;
        end else begin
            stall_run = 0;
        end
        if (stall_run >= LIMIT) stall_flag = 1'b1;
        if (xfer) begin
            void'(q.pop_front());
            sent_exp++;
        end
        if (push) q.push_back(p);
        // A packet pushed on this edge is not yet visible to the bus side.
        on_bus = (on_bus && !xfer) || (buffered > 0);
        #1;
        if (do_check) check_all();
    endtask

    task automatic tick();
        step(1'b1);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        model_clear();
        #1;
        check_all();
        in_valid = 1'b0;
        ready_in = 1'b0;
        @(negedge link_clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        model_clear();
        #3;
        check_all();
        @(negedge link_clk);
        reset = 1'b1;
        tick();

        // Single packet with a ready bus
        ready_in = 1'b1;
        in_valid = 1'b1;
        in_tag   = 4'd3;
        in_data  = 64'hA5A5;
        tick();
        in_valid = 1'b0;
        chk("single_not_yet", enable_out, 1'b0);
        tick();
        chk("single_enable", enable_out, 1'b1);
        chk("single_tag", tag_out, 4'd3);
        chk("single_data", data_out, 64'hA5A5);
        tick();
        chk("single_done_enable", enable_out, 1'b0);
        chk("single_count", sent_count, 16'd1);
        chk("single_busy", busy, 1'b0);

        // Backpressure: packet held stable for 10 stalled cycles
        async_reset();
        ready_in = 1'b0;
        in_valid = 1'b1;
        in_tag   = 4'd5;
        in_data  = {$urandom, $urandom};
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_tag", tag_out, 4'd5);
        end
        ready_in = 1'b1;
        tick();
        chk("bp_count", sent_count, 16'd1);

        // Full buffer then drain in order
        async_reset();
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_tag   = 4'(i + 8);
            in_data  = {$urandom, $urandom};
            tick();
        end
        chk("full_in_ready", in_ready, 1'b0);
        in_tag = 4'hF;
        tick();
        tick();
        in_valid = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("full_drained_count", sent_count, 16'd5);
        chk("full_drained_enable", enable_out, 1'b0);

        // Stall timeout
        async_reset();
        ready_in = 1'b0;
        in_valid = 1'b1;
        in_tag   = 4'd1;
        in_data  = {$urandom, $urandom};
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < LIMIT - 1; i++) tick();
        chk("stall_before_limit", stall_timeout, 1'b0);
        tick();
        chk("stall_at_limit", stall_timeout, 1'b1);
        tick();
        ready_in = 1'b1;
        tick();
        chk("stall_sticky", stall_timeout, 1'b1);
        chk("stall_pkt_sent", sent_count, 16'd1);

        // Reset mid-stream with packets queued and one on the bus
        async_reset();
        chk("stall_cleared", stall_timeout, 1'b0);
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_tag   = 4'($urandom);
            in_data  = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        async_reset();
        ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_stale_enable", enable_out, 1'b0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 2) != 0);
            in_tag   = 4'($urandom);
            in_data  = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // sent_count wraps after 65536 transfers
        async_reset();
        ready_in = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_tag  = 4'(i);
            in_data = 64'(i);
            step(1'b0);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        check_all();
        chk("wrap_count", sent_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
